// File: rtl/corereset_pcie_ltssm_monitor_pkg.sv
// -----------------------------------------------------------------------------
// corereset_pcie_ltssm_monitor_pkg
//   Shared definitions for the CoreResetP PCIe LTSSM monitor and the hot-reset
//   tracker downstream of it.
//   - LTSSM state encodings as driven by SDIF on PRDATA[30:26]
//   - APB "no read in flight" decode used to qualify sampled status
// -----------------------------------------------------------------------------
package corereset_pcie_ltssm_monitor_pkg;

  localparam logic [4:0] DEF_LTSSM_HOTRESET = 5'b10100;
  localparam logic [4:0] DEF_LTSSM_DISABLED = 5'b10000;
  localparam logic [4:0] DEF_LTSSM_DETECTQ  = 5'b00000;
  localparam logic [4:0] DEF_LTSSM_L0       = 5'b01111;

  // Bit positions of the LTSSM field inside PRDATA.
  localparam int unsigned LTSSM_MSB = 30;
  localparam int unsigned LTSSM_LSB = 26;

  // PRDATA only carries the LTSSM status while no APB read is being serviced.
  // A write (or an idle bus) leaves the status visible; a read replaces it.
  function automatic logic apb_no_read(input logic psel, input logic pwrite);
    return !psel || pwrite;
  endfunction

endpackage

// File: rtl/corereset_ltssm_sync.sv
// -----------------------------------------------------------------------------
// corereset_ltssm_sync
//   Plain 2-flop synchroniser bank with synchronous active-high reset.
//   Ports:
//     CLK_LTSSM  in   destination clock
//     RESET      in   synchronous reset, clears both flop stages
//     d          in   W asynchronous inputs
//     q          out  W synchronised outputs (second flop stage)
// -----------------------------------------------------------------------------
module corereset_ltssm_sync #(
  parameter int unsigned W = 7
) (
  input  logic         CLK_LTSSM,
  input  logic         RESET,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] q1;

  always_ff @(posedge CLK_LTSSM) begin
    if (RESET) begin
      q1 <= '0;
      q  <= '0;
    end else begin
      q1 <= d;
      q  <= q1;
    end
  end

endmodule

// File: rtl/corereset_pcie_ltssm_monitor.sv
// -----------------------------------------------------------------------------
// corereset_pcie_ltssm_monitor
//   Samples the LTSSM status SDIF drives on prdata[30:26], deglitches it and
//   reports the filtered state, per-state entry pulses, link-up, a saturating
//   transition count and a sticky link-training timeout.
//   Ports:
//     CLK_LTSSM            in   sole clock
//     RESET                in   synchronous reset, active-high
//     psel, pwrite         in   SDIF APB controls (asynchronous)
//     prdata[31:0]         in   SDIF APB read data, LTSSM on [30:26] (async)
//     clear                in   clears trans_count, timeout counter and flag
//     ltssm_state[4:0]     out  filtered LTSSM state
//     state_valid          out  a filtered state has been accepted
//     *_entry_p            out  one-cycle pulse when that state is accepted
//     link_up              out  filtered state is L0
//     trans_count[7:0]     out  accepted states, saturating at 8'hFF
//     link_timeout         out  sticky: training took too long
// -----------------------------------------------------------------------------
module corereset_pcie_ltssm_monitor
  import corereset_pcie_ltssm_monitor_pkg::*;
#(
  parameter int unsigned FILTER_LEN     = 4,
  parameter logic [19:0] TIMEOUT_CYCLES = 20'hFFFFF,
  parameter logic [4:0]  LTSSM_HOTRESET = DEF_LTSSM_HOTRESET,
  parameter logic [4:0]  LTSSM_DISABLED = DEF_LTSSM_DISABLED,
  parameter logic [4:0]  LTSSM_DETECTQ  = DEF_LTSSM_DETECTQ,
  parameter logic [4:0]  LTSSM_L0       = DEF_LTSSM_L0
) (
  input  logic        CLK_LTSSM,
  input  logic        RESET,
  input  logic        psel,
  input  logic        pwrite,
  input  logic [31:0] prdata,
  input  logic        clear,
  output logic [4:0]  ltssm_state,
  output logic        state_valid,
  output logic        hotreset_entry_p,
  output logic        disabled_entry_p,
  output logic        detectquiet_entry_p,
  output logic        l0_entry_p,
  output logic        link_up,
  output logic [7:0]  trans_count,
  output logic        link_timeout
);

  localparam logic [3:0]  CNT_LAST  = 4'(FILTER_LEN - 1);
  localparam logic [19:0] TCNT_LAST = TIMEOUT_CYCLES - 20'd1;

  // ---------------------------------------------------------------------------
  // Synchronise the LTSSM field together with the APB controls so that the
  // sample qualifier lines up cycle-for-cycle with the data it qualifies.
  // ---------------------------------------------------------------------------
  logic [6:0] sync_d;
  logic [6:0] sync_q;
  logic       psel_q2;
  logic       pwrite_q2;
  logic [4:0] ltssm_q2;
  logic       unused_prdata;

  assign sync_d        = {psel, pwrite, prdata[LTSSM_MSB:LTSSM_LSB]};
  assign unused_prdata = ^{prdata[31], prdata[25:0]};

  corereset_ltssm_sync #(.W(7)) u_sync (
    .CLK_LTSSM (CLK_LTSSM),
    .RESET     (RESET),
    .d         (sync_d),
    .q         (sync_q)
  );

  assign psel_q2   = sync_q[6];
  assign pwrite_q2 = sync_q[5];
  assign ltssm_q2  = sync_q[4:0];

  // Qualifier: a synchronised sample is usable (valid) only when no APB read
  // was in flight. There is no back-pressure; invalid samples are simply
  // ignored and the filter holds its progress.
  logic sample_valid;
  assign sample_valid = apb_no_read(psel_q2, pwrite_q2);

  // ---------------------------------------------------------------------------
  // Deglitch filter: a candidate must be seen FILTER_LEN consecutive valid
  // samples. Re-accepting the state already reported is suppressed, except
  // for the very first accept after reset (which may be Detect.Quiet = 0).
  // ---------------------------------------------------------------------------
  logic [4:0] cand, cand_d;
  logic [3:0] cnt, cnt_d;
  logic       accept;

  always_comb begin
    cand_d = cand;
    cnt_d  = cnt;
    accept = 1'b0;
    if (sample_valid) begin
      if (ltssm_q2 != cand) begin
        cand_d = ltssm_q2;
        cnt_d  = 4'd1;
      end else if (cnt < CNT_LAST) begin
        cnt_d = cnt + 4'd1;
      end else if (!state_valid || (cand != ltssm_state)) begin
        accept = 1'b1;
      end
    end
  end

  always_ff @(posedge CLK_LTSSM) begin
    if (RESET) begin
      cand                <= '0;
      cnt                 <= '0;
      ltssm_state         <= '0;
      state_valid         <= 1'b0;
      hotreset_entry_p    <= 1'b0;
      disabled_entry_p    <= 1'b0;
      detectquiet_entry_p <= 1'b0;
      l0_entry_p          <= 1'b0;
      link_up             <= 1'b0;
    end else begin
      cand                <= cand_d;
      cnt                 <= cnt_d;
      hotreset_entry_p    <= 1'b0;
      disabled_entry_p    <= 1'b0;
      detectquiet_entry_p <= 1'b0;
      l0_entry_p          <= 1'b0;
      if (accept) begin
        ltssm_state         <= cand;
        state_valid         <= 1'b1;
        hotreset_entry_p    <= (cand == LTSSM_HOTRESET);
        disabled_entry_p    <= (cand == LTSSM_DISABLED);
        detectquiet_entry_p <= (cand == LTSSM_DETECTQ);
        l0_entry_p          <= (cand == LTSSM_L0);
        // The state only changes on accept, so link_up follows it here.
        link_up             <= (cand == LTSSM_L0);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Transition counter: clear has priority over a coincident accept.
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK_LTSSM) begin
    if (RESET || clear) begin
      trans_count <= '0;
    end else if (accept && (trans_count != 8'hFF)) begin
      trans_count <= trans_count + 8'd1;
    end
  end

  // ---------------------------------------------------------------------------
  // Training timeout: counts cycles spent with a valid, non-L0 state. The
  // counter parks at its last value and the flag stays set until clear.
  // ---------------------------------------------------------------------------
  logic [19:0] tcnt;

  always_ff @(posedge CLK_LTSSM) begin
    if (RESET || clear) begin
      tcnt         <= '0;
      link_timeout <= 1'b0;
    end else if (link_up) begin
      tcnt <= '0;
    end else if (state_valid) begin
      if (tcnt == TCNT_LAST) begin
        link_timeout <= 1'b1;
      end else begin
        tcnt <= tcnt + 20'd1;
      end
    end
  end

endmodule

// File: tb/tb_corereset_pcie_ltssm_monitor.sv
// -----------------------------------------------------------------------------
// tb_corereset_pcie_ltssm_monitor
//   Directed bench for the LTSSM monitor: latency, glitch rejection, APB-read
//   stalls, entry-pulse ordering, timeout, clear priority, saturation and
//   reset in the middle of filtering.
// -----------------------------------------------------------------------------
module tb_corereset_pcie_ltssm_monitor;

  localparam logic [4:0] HOT = 5'b10100;
  localparam logic [4:0] DQ  = 5'b00000;
  localparam logic [4:0] L0  = 5'b01111;

  // pulse vector order: {hotreset, disabled, detectquiet, l0}
  localparam logic [3:0] P_NONE = 4'b0000;
  localparam logic [3:0] P_HOT  = 4'b1000;
  localparam logic [3:0] P_DQ   = 4'b0010;
  localparam logic [3:0] P_L0   = 4'b0001;

  // ---------------- clock / reset ----------------
  logic        CLK_LTSSM = 1'b0;
  logic        RESET;
  logic        psel;
  logic        pwrite;
  logic [31:0] prdata;
  logic        clear;
  logic [4:0]  ltssm_state;
  logic        state_valid;
  logic        hotreset_entry_p;
  logic        disabled_entry_p;
  logic        detectquiet_entry_p;
  logic        l0_entry_p;
  logic        link_up;
  logic [7:0]  trans_count;
  logic        link_timeout;

  always #5 CLK_LTSSM = ~CLK_LTSSM;

  corereset_pcie_ltssm_monitor #(
    .FILTER_LEN     (4),
    .TIMEOUT_CYCLES (20'd16)
  ) dut (
    .CLK_LTSSM           (CLK_LTSSM),
    .RESET               (RESET),
    .psel                (psel),
    .pwrite              (pwrite),
    .prdata              (prdata),
    .clear               (clear),
    .ltssm_state         (ltssm_state),
    .state_valid         (state_valid),
    .hotreset_entry_p    (hotreset_entry_p),
    .disabled_entry_p    (disabled_entry_p),
    .detectquiet_entry_p (detectquiet_entry_p),
    .l0_entry_p          (l0_entry_p),
    .link_up             (link_up),
    .trans_count         (trans_count),
    .link_timeout        (link_timeout)
  );

  logic [3:0]  pulses;
  logic [19:0] all_out;
  assign pulses  = {hotreset_entry_p, disabled_entry_p, detectquiet_entry_p, l0_entry_p};
  assign all_out = {ltssm_state, state_valid, pulses, link_up, trans_count, link_timeout};

  int n_pass  = 0;
  int n_total = 0;

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge CLK_LTSSM);
    #1;
  endtask

  // Unrelated prdata bits are randomised; only [30:26] should matter.
  task automatic set_ltssm(input logic [4:0] v);
    logic [31:0] r;
    r       = $urandom;
    r[30:26] = v;
    prdata  = r;
  endtask

  task automatic do_reset(input int cycles);
    RESET = 1'b1;
    repeat (cycles) step();
    RESET = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    psel = 1'b0; pwrite = 1'b0; clear = 1'b0;
    set_ltssm(HOT);
    do_reset(3);
    n_total++;
    if (all_out !== 20'h0) $display("FAIL reset_outputs: got %h want %h", all_out, 20'h0);
    else n_pass++;
  endtask

  task automatic test_latency();
    logic [3:0] p_or;
    p_or = '0;
    repeat (5) begin step(); p_or |= pulses; end
    n_total++;
    if ({state_valid, ltssm_state, p_or} !== {1'b0, 5'd0, P_NONE})
      $display("FAIL lat_early: got valid=%b state=%b pulses=%b want 0/00000/0000", state_valid, ltssm_state, p_or);
    else n_pass++;
    step();
    n_total++;
    if ({ltssm_state, state_valid, pulses, trans_count, link_up} !== {HOT, 1'b1, P_HOT, 8'd1, 1'b0})
      $display("FAIL lat_accept: got state=%b valid=%b pulses=%b cnt=%0d up=%b want 10100/1/1000/1/0",
               ltssm_state, state_valid, pulses, trans_count, link_up);
    else n_pass++;
    step();
    n_total++;
    if (pulses !== P_NONE) $display("FAIL lat_pulse_width: got %b want %b", pulses, P_NONE);
    else n_pass++;
  endtask

  task automatic test_glitch();
    logic [3:0] p_or;
    set_ltssm(L0);
    repeat (6) step();
    n_total++;
    if ({ltssm_state, pulses, link_up, trans_count} !== {L0, P_L0, 1'b1, 8'd2})
      $display("FAIL glitch_to_l0: got state=%b pulses=%b up=%b cnt=%0d want 01111/0001/1/2",
               ltssm_state, pulses, link_up, trans_count);
    else n_pass++;
    p_or = '0;
    set_ltssm(HOT);
    repeat (3) begin step(); p_or |= pulses; end
    set_ltssm(L0);
    repeat (12) begin step(); p_or |= pulses; end
    n_total++;
    if ({p_or, ltssm_state, trans_count, link_up} !== {P_NONE, L0, 8'd2, 1'b1})
      $display("FAIL glitch_reject: got pulses=%b state=%b cnt=%0d up=%b want 0000/01111/2/1",
               p_or, ltssm_state, trans_count, link_up);
    else n_pass++;
  endtask

  task automatic test_apb_read();
    logic [3:0] p_or;
    p_or = '0;
    psel = 1'b1; pwrite = 1'b0;
    set_ltssm(HOT);
    repeat (10) begin step(); p_or |= pulses; end
    psel = 1'b0;
    repeat (5) begin step(); p_or |= pulses; end
    n_total++;
    if ({p_or, ltssm_state} !== {P_NONE, L0})
      $display("FAIL apb_hold: got pulses=%b state=%b want 0000/01111", p_or, ltssm_state);
    else n_pass++;
    step();
    n_total++;
    if ({ltssm_state, pulses, trans_count} !== {HOT, P_HOT, 8'd3})
      $display("FAIL apb_accept: got state=%b pulses=%b cnt=%0d want 10100/1000/3",
               ltssm_state, pulses, trans_count);
    else n_pass++;
  endtask

  task automatic test_sequence();
    logic [3:0] seen[$];
    logic [4:0] seq[3];
    logic [3:0] exp_p[3];
    seq   = '{HOT, DQ, L0};
    exp_p = '{P_HOT, P_DQ, P_L0};
    do_reset(2);
    for (int i = 0; i < 3; i++) begin
      set_ltssm(seq[i]);
      repeat (20) begin
        step();
        if (pulses != P_NONE) seen.push_back(pulses);
      end
    end
    n_total++;
    if (seen.size() !== 3) $display("FAIL seq_count: got %0d pulses want 3", seen.size());
    else begin
      n_pass++;
      for (int i = 0; i < 3; i++) begin
        n_total++;
        if (seen[i] !== exp_p[i]) $display("FAIL seq_order%0d: got %b want %b", i, seen[i], exp_p[i]);
        else n_pass++;
      end
    end
    n_total++;
    if ({link_up, trans_count} !== {1'b1, 8'd3})
      $display("FAIL seq_final: got up=%b cnt=%0d want 1/3", link_up, trans_count);
    else n_pass++;
  endtask

  task automatic test_timeout();
    int waited;
    do_reset(2);
    set_ltssm(DQ);
    waited = 0;
    while (!state_valid && waited < 20) begin step(); waited++; end
    n_total++;
    if ({state_valid, pulses} !== {1'b1, P_DQ})
      $display("FAIL to_first_accept: got valid=%b pulses=%b after %0d cycles want 1/0010", state_valid, pulses, waited);
    else n_pass++;
    repeat (15) step();
    n_total++;
    if (link_timeout !== 1'b0) $display("FAIL to_early: got %b want 0", link_timeout);
    else n_pass++;
    step();
    n_total++;
    if (link_timeout !== 1'b1) $display("FAIL to_rise: got %b want 1", link_timeout);
    else n_pass++;
    set_ltssm(L0);
    repeat (6) step();
    n_total++;
    if ({link_up, link_timeout} !== 2'b11)
      $display("FAIL to_sticky: got up=%b timeout=%b want 1/1", link_up, link_timeout);
    else n_pass++;
    clear = 1'b1;
    step();
    clear = 1'b0;
    n_total++;
    if ({link_timeout, trans_count} !== {1'b0, 8'd0})
      $display("FAIL to_clear: got timeout=%b cnt=%0d want 0/0", link_timeout, trans_count);
    else n_pass++;
    repeat (5) step();
    n_total++;
    if (link_timeout !== 1'b0) $display("FAIL to_stay_clear: got %b want 0", link_timeout);
    else n_pass++;
    // clear coincident with an accept: state and pulse happen, count stays 0
    set_ltssm(HOT);
    repeat (5) step();
    clear = 1'b1;
    step();
    clear = 1'b0;
    n_total++;
    if ({ltssm_state, pulses, trans_count} !== {HOT, P_HOT, 8'd0})
      $display("FAIL clear_vs_accept: got state=%b pulses=%b cnt=%0d want 10100/1000/0",
               ltssm_state, pulses, trans_count);
    else n_pass++;
  endtask

  task automatic test_saturation();
    int n_acc;
    n_acc = 0;
    do_reset(2);
    for (int i = 0; i < 300; i++) begin
      set_ltssm((i % 2 == 0) ? HOT : L0);
      repeat (6) begin
        step();
        if (pulses != P_NONE) n_acc++;
      end
      if (i == 255) begin
        n_total++;
        if (trans_count !== 8'hFF) $display("FAIL sat_reach: got %h want ff", trans_count);
        else n_pass++;
      end
    end
    n_total++;
    if (n_acc !== 300) $display("FAIL sat_accepts: got %0d want 300", n_acc);
    else n_pass++;
    n_total++;
    if (trans_count !== 8'hFF) $display("FAIL sat_nowrap: got %h want ff", trans_count);
    else n_pass++;
  endtask

  task automatic test_reset_mid_filter();
    set_ltssm(HOT);
    repeat (4) step();   // filter now holds cand=HOT, cnt=2
    RESET = 1'b1;
    step();
    n_total++;
    if (all_out !== 20'h0) $display("FAIL midrst_outputs: got %h want %h", all_out, 20'h0);
    else n_pass++;
    step();
    RESET = 1'b0;
    repeat (5) step();
    n_total++;
    if (state_valid !== 1'b0) $display("FAIL midrst_no_early: got valid=%b want 0", state_valid);
    else n_pass++;
    step();
    n_total++;
    if ({ltssm_state, pulses, trans_count} !== {HOT, P_HOT, 8'd1})
      $display("FAIL midrst_reacquire: got state=%b pulses=%b cnt=%0d want 10100/1000/1",
               ltssm_state, pulses, trans_count);
    else n_pass++;
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    RESET = 1'b1; psel = 1'b0; pwrite = 1'b0; clear = 1'b0; prdata = '0;
    test_reset();
    test_latency();
    test_glitch();
    test_apb_read();
    test_sequence();
    test_timeout();
    test_saturation();
    test_reset_mid_filter();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
